uart_tx_mmio: RTL and testbench
===============================

// Module: uart_tx_mmio
// PURPOSE
//  Memory-mapped UART transmitter on the single-cycle core's data-memory port, alongside data RAM.
//  Consumes MemWrite/ALUResult/WriteData; returns ReadData combinationally, same cycle as the access.
//  Buffers bytes in a small TX FIFO and serialises them 8N1, LSB first, on tx.
// PARAMETERS
//  BASE_ADDR    32'h0000_1000  16-byte aligned register window base
//  FIFO_DEPTH   4              TX FIFO entries, power of two, >= 2
//  DEFAULT_DIV  16'd868        reset value of BAUDDIV (clk cycles per bit)
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-high reset
//  MemWrite   in   1   store strobe from core
//  ALUResult  in   32  byte address from core
//  WriteData  in   32  store data from core
//  Sel        out  1   1 when ALUResult hits window; top-level read mux selects ReadData
//  ReadData   out  32  register read data, combinational
//  tx         out  1   serial line, registered, idle high
// BEHAVIOUR
//  Decode: hit = ALUResult[31:4]==BASE_ADDR[31:4]; offset = ALUResult[3:2]. Writes act only when hit&MemWrite.
//  Registers:
//   0x0 TXDATA  W: push WriteData[7:0]; R: 0
//   0x4 STATUS  R: {28'b0, ovf, busy, full, empty}; W: WriteData[3]=1 clears ovf
//   0x8 BAUDDIV R/W [15:0], upper bits read 0
//   0xC         reads 0, writes ignored
//  Reads have no side effects. ReadData=0 when !hit.
//  Reset (async): tx=1, state IDLE, FIFO empty, ovf=0, BAUDDIV=DEFAULT_DIV, bit/baud counters 0.
//  FIFO push: TXDATA write accepted if !full or pop in same cycle.
//   Otherwise byte dropped and ovf set (sticky).
//   Push+pop same cycle: count unchanged.
//  FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   IDLE: tx=1. If !empty: pop head into shift reg, latch period=max(BAUDDIV,2), go START.
//   START: tx=0 for period cycles.
//   DATA: 8 bits, each period cycles, shift reg LSB first.
//   STOP: tx=1 for period cycles; then IDLE. Back-to-back frames if FIFO non-empty.
//    Min gap = 1 IDLE cycle.
//  Latency: TXDATA write at edge N (FSM idle, FIFO empty) -> pop at edge N+1 -> tx=0 after edge N+1.
//  Frame length = 10*period cycles. Mid-frame BAUDDIV write affects next frame only.
//  busy = state!=IDLE. full/empty reflect FIFO count after the current edge.
//  Reset mid-frame: tx returns high immediately, frame and FIFO contents discarded.
// STRUCTURE
//  Shared header riscv_mmio_defs.vh:
//   UART register offsets, STATUS bit positions, FSM state encodings (2-bit), default BASE_ADDR.
//  Sub-module sync_fifo (WIDTH=8, DEPTH=FIFO_DEPTH):
//   push/pop/full/empty, same async reset, pointer wrap with extra MSB.
//  Top holds decode, register file, FSM, baud counter, bit counter, shift reg.
// TESTING
//  1 Reset, BAUDDIV=4, write 0xA5 to TXDATA -> tx low 1 cycle after push.
//    Bit pattern 0,1,0,1,0,0,1,0,1,1, each 4 cycles. busy=1 for 40 cycles.
//  2 Write 5 bytes back-to-back, FIFO_DEPTH=4, BAUDDIV=868.
//    -> first byte popped, remaining 4 fill FIFO: full=1, no drop, ovf=0.
//    6th write while full -> ovf=1. Write STATUS 0x8 -> ovf=0.
//  3 Read STATUS/BAUDDIV/0xC after reset -> 0x1 / 0x364 / 0.
//    Read outside window -> Sel=0, ReadData=0.
//  4 Write BAUDDIV=0 -> frame uses period 2 (20 cycles).
//    BAUDDIV changed mid-frame -> current frame keeps old period.
//  5 Assert reset mid DATA bit -> tx=1 immediately, STATUS=0x1 after release, no further frame.
//  6 FIFO full, TXDATA write in same cycle as IDLE pop -> accepted, full stays 1, ovf=0.

Source files
------------

// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions, transmitter FSM states and the bit-period helper.
package uart_tx_mmio_pkg;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_1000;

   // Word offsets within the 16-byte register window (ALUResult[3:2])
   localparam logic [1:0] OFF_TXDATA  = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_BAUDDIV = 2'd2;
   localparam logic [1:0] OFF_RSVD    = 2'd3;

   localparam int STAT_EMPTY = 0;
   localparam int STAT_FULL  = 1;
   localparam int STAT_BUSY  = 2;
   localparam int STAT_OVF   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   // A divider below 2 would leave no room for the counter compare, so clamp it.
   function automatic logic [15:0] eff_period(input logic [15:0] div);
      return (div < 16'd2) ? 16'd2 : div;
   endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-memory port of the single-cycle core as seen by a memory-mapped peripheral.
// Protocol: no valid/ready; every cycle is an access. A store takes effect at the
// rising edge while MemWrite is high; Sel and ReadData follow ALUResult combinationally.
interface uart_tx_mmio_if;
   logic        MemWrite;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic        Sel;
   logic [31:0] ReadData;

   modport master (output MemWrite, output ALUResult, output WriteData,
                   input  Sel,      input  ReadData);
   modport slave  (input  MemWrite, input  ALUResult, input  WriteData,
                   output Sel,      output ReadData);
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push while full is legal only when
// the same cycle also pops (the head is read out before its slot is overwritten).
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO and the serialiser.
// The FSM state is exported on dbg_state.
module uart_tx_mmio
   import uart_tx_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic           clk,
   input  logic           reset,
   uart_tx_mmio_if.slave  bus,
   output logic           tx,
   output uart_state_e    dbg_state
);

   logic        hit;
   logic [1:0]  offset;
   logic        wr_txdata, wr_status, wr_bauddiv;
   logic        push, pop;
   logic        fifo_full, fifo_empty;
   logic [7:0]  fifo_rdata;
   logic        ovf_q;
   logic [15:0] bauddiv_q;
   logic        busy;
   logic [31:0] rdata;

   uart_state_e state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [15:0] period_q, period_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;

   logic unused_bits;
   assign unused_bits = ^{bus.ALUResult[1:0], bus.WriteData[31:16]};

   assign hit        = (bus.ALUResult[31:4] == BASE_ADDR[31:4]);
   assign offset     = bus.ALUResult[3:2];
   assign wr_txdata  = hit && bus.MemWrite && (offset == OFF_TXDATA);
   assign wr_status  = hit && bus.MemWrite && (offset == OFF_STATUS);
   assign wr_bauddiv = hit && bus.MemWrite && (offset == OFF_BAUDDIV);

   // A full FIFO still accepts a byte when the serialiser pops in the same cycle.
   assign push = wr_txdata && (!fifo_full || pop);

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (bus.WriteData[7:0]),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q     <= 1'b0;
         bauddiv_q <= DEFAULT_DIV;
      end else begin
         if (wr_txdata && fifo_full && !pop)           ovf_q <= 1'b1;
         else if (wr_status && bus.WriteData[STAT_OVF]) ovf_q <= 1'b0;
         if (wr_bauddiv) bauddiv_q <= bus.WriteData[15:0];
      end
   end

   assign busy = (state_q != ST_IDLE);

   always_comb begin
      rdata = 32'b0;
      if (hit) begin
         case (offset)
            OFF_STATUS:  rdata = {28'b0, ovf_q, busy, fifo_full, fifo_empty};
            OFF_BAUDDIV: rdata = {16'b0, bauddiv_q};
            default:     rdata = 32'b0;
         endcase
      end
   end

   assign bus.Sel      = hit;
   assign bus.ReadData = rdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         baud_q   <= 16'd0;
         period_q <= 16'd2;
         bit_q    <= 3'd0;
         shift_q  <= 8'd0;
         tx_q     <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         period_q <= period_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
      end
   end

   // tx is computed one step ahead so the line is a flop output that changes on
   // the same edge as the state it belongs to.
   always_comb begin
      state_d  = state_q;
      baud_d   = baud_q;
      period_d = period_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      tx_d     = tx_q;
      pop      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop      = 1'b1;
               shift_d  = fifo_rdata;
               period_d = eff_period(bauddiv_q);
               baud_d   = 16'd0;
               bit_d    = 3'd0;
               tx_d     = 1'b0;
               state_d  = ST_START;
            end
         end
         ST_START: begin
            if (baud_q == period_q - 16'd1) begin
               baud_d  = 16'd0;
               tx_d    = shift_q[0];
               state_d = ST_DATA;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         ST_DATA: begin
            if (baud_q == period_q - 16'd1) begin
               baud_d = 16'd0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = ST_STOP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shift_d = shift_q >> 1;
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         ST_STOP: begin
            if (baud_q == period_q - 16'd1) begin
               baud_d  = 16'd0;
               tx_d    = 1'b1;
               state_d = ST_IDLE;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign tx        = tx_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: register vector table, hand-written timing sequences and
// random byte streams decoded by a serial receiver model.
module tb_uart_tx_mmio;
   import uart_tx_mmio_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_1000;
   localparam logic [31:0] A_TX = BASE + 32'h0;
   localparam logic [31:0] A_ST = BASE + 32'h4;
   localparam logic [31:0] A_BD = BASE + 32'h8;
   localparam logic [31:0] A_RS = BASE + 32'hC;

   logic        clk = 1'b0;
   logic        reset;
   logic        tx;
   uart_state_e dbg_state;

   uart_tx_mmio_if bus();

   uart_tx_mmio #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .DEFAULT_DIV(16'd868)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .tx        (tx),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; drives one access, samples at the negedge, returns at the next posedge+1.
   task automatic bus_cyc(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          output logic sel, output logic [31:0] rd, output logic txs);
      bus.MemWrite  = we;
      bus.ALUResult = addr;
      bus.WriteData = data;
      @(negedge clk);
      sel = bus.Sel;
      rd  = bus.ReadData;
      txs = tx;
      @(posedge clk);
      #1;
      bus.MemWrite = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      logic s; logic [31:0] r; logic t;
      bus_cyc(1'b1, a, d, s, r, t);
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] r);
      logic s; logic t;
      bus_cyc(1'b0, a, 32'h0, s, r, t);
   endtask

   task automatic idle(input int n);
      logic [31:0] r;
      for (int i = 0; i < n; i++) rd(32'h0, r);
   endtask

   task automatic do_reset();
      bus.MemWrite = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [9:0] frame_bits(input logic [7:0] b);
      return {1'b1, b, 1'b0};
   endfunction

   // Length of each busy stretch, in cycles.
   int run_len = 0;
   int runs_q[$];
   always @(negedge clk) begin
      if (reset) run_len = 0;
      else if (dbg_state != ST_IDLE) run_len++;
      else if (run_len > 0) begin
         runs_q.push_back(run_len);
         run_len = 0;
      end
   end

   // Serial receiver: samples each bit in the middle of its period.
   bit         mon_en = 1'b0;
   int         mon_period = 2;
   logic [7:0] exp_q[$];
   always begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin : frame_rx
         int p;
         int cur;
         logic [7:0] b;
         p = mon_period;
         cur = 0;
         for (int i = 0; i < 8; i++) begin
            repeat ((i + 1) * p + p / 2 - cur) @(negedge clk);
            cur = (i + 1) * p + p / 2;
            b[i] = tx;
         end
         repeat (9 * p + p / 2 - cur) @(negedge clk);
         check("stop_bit", {31'b0, tx}, 32'd1);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rx_unexpected: got byte 0x%0h, required no frame", b);
         end else begin
            check("rx_byte", {24'b0, b}, {24'b0, exp_q.pop_front()});
         end
      end
   end

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_sel;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[15];

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      logic        s;
      logic [31:0] r;
      logic        t;
      int          k;
      int          lows;
      logic [7:0]  byt;
      int          period;
      logic [9:0]  fb;

      bus.MemWrite  = 1'b0;
      bus.ALUResult = 32'h0;
      bus.WriteData = 32'h0;
      reset = 1'b1;
      #2;
      check("reset_tx_async", {31'b0, tx}, 32'd1);
      do_reset();

      check("reset_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
      bus_cyc(1'b0, A_ST, 32'h0, s, r, t);
      check("reset_status", r, 32'h1);
      check("reset_tx", {31'b0, t}, 32'd1);

      // Register map vectors
      vecs[0]  = '{1'b0, A_ST,             32'h0,         1'b1, 32'h1};
      vecs[1]  = '{1'b0, A_BD,             32'h0,         1'b1, 32'h364};
      vecs[2]  = '{1'b0, A_RS,             32'h0,         1'b1, 32'h0};
      vecs[3]  = '{1'b0, A_TX,             32'h0,         1'b1, 32'h0};
      vecs[4]  = '{1'b0, BASE + 32'h5,     32'h0,         1'b1, 32'h1};
      vecs[5]  = '{1'b0, 32'h0000_2004,    32'h0,         1'b0, 32'h0};
      vecs[6]  = '{1'b0, 32'h0000_0FFC,    32'h0,         1'b0, 32'h0};
      vecs[7]  = '{1'b1, A_BD,             32'hABCD_1234, 1'b1, 32'h364};
      vecs[8]  = '{1'b0, A_BD,             32'h0,         1'b1, 32'h1234};
      vecs[9]  = '{1'b1, A_RS,             32'hFFFF_FFFF, 1'b1, 32'h0};
      vecs[10] = '{1'b0, A_RS,             32'h0,         1'b1, 32'h0};
      vecs[11] = '{1'b1, 32'h0000_2008,    32'h55,        1'b0, 32'h0};
      vecs[12] = '{1'b0, A_BD,             32'h0,         1'b1, 32'h1234};
      vecs[13] = '{1'b1, A_ST,             32'h8,         1'b1, 32'h1};
      vecs[14] = '{1'b0, BASE + 32'h14,    32'h0,         1'b0, 32'h0};
      for (int i = 0; i < 15; i++) begin
         bus_cyc(vecs[i].we, vecs[i].addr, vecs[i].wdata, s, r, t);
         check($sformatf("vec%0d_sel", i), {31'b0, s}, {31'b0, vecs[i].exp_sel});
         check($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
      end

      // Single frame at period 4, checked cycle by cycle
      do_reset();
      wr(A_BD, 32'd4);
      wr(A_TX, 32'hA5);
      bus_cyc(1'b0, A_ST, 32'h0, s, r, t);
      check("a5_pre_tx", {31'b0, t}, 32'd1);
      check("a5_pre_status", r, 32'h0);
      fb = frame_bits(8'hA5);
      for (int j = 0; j < 40; j++) begin
         bus_cyc(1'b0, A_ST, 32'h0, s, r, t);
         check($sformatf("a5_tx_c%0d", j), {31'b0, t}, {31'b0, fb[j / 4]});
         check($sformatf("a5_status_c%0d", j), r, 32'h5);
      end
      bus_cyc(1'b0, A_ST, 32'h0, s, r, t);
      check("a5_post_tx", {31'b0, t}, 32'd1);
      check("a5_post_status", r, 32'h1);

      // Fill the FIFO at the default divider, then overflow and clear
      do_reset();
      for (int i = 0; i < 5; i++) wr(A_TX, 32'h10 + i);
      rd(A_ST, r);
      check("fill_status", r, 32'h6);
      wr(A_TX, 32'h99);
      rd(A_ST, r);
      check("ovf_set", r, 32'hE);
      wr(A_ST, 32'h7);
      rd(A_ST, r);
      check("ovf_kept", r, 32'hE);
      wr(A_ST, 32'h8);
      rd(A_ST, r);
      check("ovf_cleared", r, 32'h6);

      // Divider 0 clamps to 2; a mid-frame change only affects the next frame
      do_reset();
      runs_q.delete();
      wr(A_BD, 32'd0);
      rd(A_BD, r);
      check("bauddiv_zero", r, 32'h0);
      wr(A_TX, 32'h3C);
      wr(A_TX, 32'h81);
      idle(4);
      wr(A_BD, 32'd3);
      idle(70);
      check("runs_count", 32'(runs_q.size()), 32'd2);
      check("run0_len", (runs_q.size() > 0) ? 32'(runs_q[0]) : 32'hFFFF_FFFF, 32'd20);
      check("run1_len", (runs_q.size() > 1) ? 32'(runs_q[1]) : 32'hFFFF_FFFF, 32'd30);

      // Reset in the middle of a data bit
      do_reset();
      wr(A_BD, 32'd4);
      wr(A_TX, 32'h00);
      wr(A_TX, 32'hFF);
      for (k = 0; k < 20 && dbg_state != ST_DATA; k++) idle(1);
      check("reach_data", {31'b0, (dbg_state == ST_DATA)}, 32'd1);
      idle(5);
      check("mid_data_tx", {31'b0, tx}, 32'd0);
      #2;
      reset = 1'b1;
      #1;
      check("reset_mid_tx", {31'b0, tx}, 32'd1);
      check("reset_mid_state", {30'b0, dbg_state}, {30'b0, ST_IDLE});
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      runs_q.delete();
      rd(A_ST, r);
      check("reset_mid_status", r, 32'h1);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         bus_cyc(1'b0, 32'h0, 32'h0, s, r, t);
         if (t == 1'b0) lows++;
      end
      check("reset_mid_no_frame", lows, 32'd0);
      check("reset_mid_no_busy", 32'(runs_q.size()), 32'd0);

      // Push into a full FIFO on the cycle the serialiser pops
      do_reset();
      wr(A_BD, 32'd0);
      mon_period = 2;
      exp_q.delete();
      mon_en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(8'(8'h11 + i));
         wr(A_TX, 32'h11 + i);
      end
      rd(A_ST, r);
      check("pp_full_before", r, 32'h6);
      for (k = 0; k < 40 && dbg_state != ST_IDLE; k++) idle(1);
      check("pp_reach_idle", {31'b0, (dbg_state == ST_IDLE)}, 32'd1);
      exp_q.push_back(8'h16);
      wr(A_TX, 32'h16);
      rd(A_ST, r);
      check("pp_status_after", r, 32'h6);
      for (k = 0; k < 400 && exp_q.size() != 0; k++) idle(1);
      idle(3);
      check("pp_all_received", 32'(exp_q.size()), 32'd0);
      mon_en = 1'b0;

      // Random byte streams at random dividers
      do_reset();
      for (int run = 0; run < 3; run++) begin
         k = $urandom_range(0, 5);
         period = (k < 2) ? 2 : k;
         wr(A_BD, 32'(k));
         mon_period = period;
         exp_q.delete();
         mon_en = 1'b1;
         for (int n = 0; n < 10; n++) begin
            for (k = 0; k < 200; k++) begin
               rd(A_ST, r);
               if (r[STAT_FULL] == 1'b0) break;
            end
            check("rnd_not_full", {31'b0, r[STAT_FULL]}, 32'd0);
            byt = 8'($urandom_range(0, 255));
            exp_q.push_back(byt);
            wr(A_TX, {24'b0, byt});
            idle($urandom_range(0, 12));
         end
         for (k = 0; k < 2000 && (exp_q.size() != 0 || dbg_state != ST_IDLE); k++) idle(1);
         idle(2);
         check($sformatf("rnd%0d_drained", run), 32'(exp_q.size()), 32'd0);
         rd(A_ST, r);
         check($sformatf("rnd%0d_status", run), r, 32'h1);
         mon_en = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
